// File: rtl/spi_config_sequencer.sv
// spi_config_sequencer: boot-time register-table writer with a mode-0 SPI master.
// Walks cfg_table entries, writes each to its slave, optionally reads back and retries.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   start             one-cycle pulse, runs the table from entry 0
//   cfg_table         entry i at [20i+19:20i] = {slave[3:0], rsvd, addr[6:0], data[7:0]}
//   busy/done/error   sequence status; err_index = failing entry while error=1
//   entry_index       entry currently being processed
//   miso/mosi/sclk    SPI data and clock (CPOL=0, CPHA=0)
//   ss_n              active-low chip selects, one per slave
module spi_config_sequencer #(
   parameter int NUM_ENTRIES = 5,
   parameter int NUM_SLAVES  = 2,
   parameter int CLK_DIV     = 4,
   parameter bit VERIFY      = 1'b0,
   parameter int MAX_RETRY   = 2,
   parameter bit AUTO_START  = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [20*NUM_ENTRIES-1:0] cfg_table,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [7:0]                err_index,
   output logic [7:0]                entry_index,
   input  logic                      miso,
   output logic                      mosi,
   output logic                      sclk,
   output logic [NUM_SLAVES-1:0]     ss_n
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_WRITE, S_GAP_W, S_READ,
      S_GAP_R, S_CHECK, S_NEXT, S_DONE, S_ERROR
   } state_t;

   state_t      state, nxt;
   logic        boot_q;
   logic [15:0] cnt;
   logic [3:0]  bit_cnt;
   logic        sclk_q;
   logic [15:0] tx_sr;
   logic [7:0]  rx_sr;
   logic [3:0]  slv_q, slv_w;
   logic [14:0] frm_q, frm_w;
   logic [3:0]  retry;
   logic        go, idle_like, in_frame, in_gap;
   logic        tick, frame_end, gap_end, last;

   // Entry fields for the current index; the reserved bit is never needed.
   assign slv_w = cfg_table[20*int'(entry_index)+16 +: 4];
   assign frm_w = cfg_table[20*int'(entry_index) +: 15];

   // boot_q is high only in the first cycle after reset release.
   assign go        = start | boot_q;
   assign idle_like = (state == S_IDLE) || (state == S_DONE) ||
                      (state == S_ERROR);
   assign in_frame  = (state == S_WRITE) || (state == S_READ);
   assign in_gap    = (state == S_GAP_W) || (state == S_GAP_R);

   // tick ends one SCLK half-period; the frame ends after bit 15's high half.
   assign tick      = in_frame && (cnt == 16'(CLK_DIV-1));
   assign frame_end = tick && sclk_q && (bit_cnt == 4'd15);
   assign gap_end   = in_gap && (cnt == 16'(2*CLK_DIV-1));
   assign last      = (entry_index == 8'(NUM_ENTRIES-1));

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE, S_DONE, S_ERROR:
            if (go) nxt = S_LOAD;
         S_LOAD:
            nxt = ({1'b0, slv_w} >= 5'(NUM_SLAVES)) ? S_NEXT : S_WRITE;
         S_WRITE:
            if (frame_end) nxt = S_GAP_W;
         S_GAP_W:
            if (gap_end) nxt = VERIFY ? S_READ : S_NEXT;
         S_READ:
            if (frame_end) nxt = S_GAP_R;
         S_GAP_R:
            if (gap_end) nxt = S_CHECK;
         S_CHECK:
            if (rx_sr == frm_q[7:0])        nxt = S_NEXT;
            else if (retry < 4'(MAX_RETRY)) nxt = S_WRITE;
            else                            nxt = S_ERROR;
         S_NEXT:
            nxt = last ? S_DONE : S_LOAD;
         default:
            nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         boot_q      <= AUTO_START;
         cnt         <= '0;
         bit_cnt     <= '0;
         sclk_q      <= 1'b0;
         tx_sr       <= '0;
         rx_sr       <= '0;
         slv_q       <= '0;
         frm_q       <= '0;
         retry       <= '0;
         entry_index <= '0;
      end else begin
         boot_q <= 1'b0;
         cnt    <= (state != nxt || tick) ? '0 : cnt + 16'd1;
         if (tick) begin
            sclk_q <= ~sclk_q;
            // Sample on the rising edge, shift mosi on the falling edge.
            if (!sclk_q) begin
               rx_sr <= {rx_sr[6:0], miso};
            end else begin
               tx_sr   <= {tx_sr[14:0], 1'b0};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end
         if (state == S_LOAD) begin
            slv_q <= slv_w;
            frm_q <= frm_w;
            retry <= '0;
         end
         // In LOAD the entry register is not yet valid, so use the table.
         if (nxt == S_WRITE && state != S_WRITE)
            tx_sr <= {1'b0, (state == S_LOAD) ? frm_w : frm_q};
         if (nxt == S_READ && state != S_READ)
            tx_sr <= {1'b1, frm_q[14:8], 8'h00};
         if (state == S_CHECK && nxt == S_WRITE)
            retry <= retry + 4'd1;
         if (go && idle_like)
            entry_index <= '0;
         else if (state == S_NEXT && !last)
            entry_index <= entry_index + 8'd1;
      end
   end

   assign busy      = !idle_like;
   assign done      = (state == S_DONE);
   assign error     = (state == S_ERROR);
   assign err_index = error ? entry_index : 8'd0;
   assign sclk      = sclk_q;
   assign mosi      = in_frame & tx_sr[15];

   always_comb begin
      ss_n = '1;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (in_frame && slv_q == 4'(i)) ss_n[i] = 1'b0;
   end

endmodule
